// File: rtl/wide_alu_result_streamer_if.sv
// Beat stream carrying one narrow slice of a wide ALU result per transfer.
// Master drives data/valid/last/beat_idx; slave drives ready.
interface wide_alu_result_streamer_if #(
    parameter int BEAT_WIDTH = 32,
    parameter int IDX_WIDTH  = 4
);
    logic [BEAT_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [IDX_WIDTH-1:0]  beat_idx;

    modport master (
        output data,
        output valid,
        output last,
        output beat_idx,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        input  beat_idx,
        output ready
    );
endinterface

// File: rtl/wide_alu_result_streamer.sv
// Captures a wide ALU result on done_i and streams it out as narrow beats.
// Ports: clk_i/rst_i (async active-high), done_i/result_i capture,
//   clear_err_i, out_if (master: data/valid/ready/last/beat_idx),
//   busy_o, overrun_o (sticky drop flag), drop_cnt_o (saturating drops).
// Optional macro WIDE_ALU_STREAM_TRIM_EN: stop after highest nonzero beat.
module wide_alu_result_streamer #(
    parameter int RESULT_WIDTH = 512,
    parameter int BEAT_WIDTH   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    done_i,
    input  logic [RESULT_WIDTH-1:0] result_i,
    input  logic                    clear_err_i,
    wide_alu_result_streamer_if.master out_if,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic [7:0]              drop_cnt_o
);
    localparam int NUM_BEATS = RESULT_WIDTH / BEAT_WIDTH;
    localparam int IDX_WIDTH = $clog2(NUM_BEATS);

    localparam logic [IDX_WIDTH-1:0] LAST_FULL = IDX_WIDTH'(NUM_BEATS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    typedef logic [NUM_BEATS-1:0][BEAT_WIDTH-1:0] beats_t;

    state_t               state_q, state_d;
    beats_t               shadow_q, shadow_d;
    logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0] last_idx_q, last_idx_d;
    logic                 overrun_q, overrun_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    beats_t               result_beats;
    logic [IDX_WIDTH-1:0] cap_last_idx;
    logic                 streaming;
    logic                 xfer;
    logic                 final_xfer;
    logic                 drop;

    assign result_beats = result_i;

`ifdef WIDE_ALU_STREAM_TRIM_EN
    // Highest nonzero beat; an all-zero result still sends beat 0.
    always_comb begin
        cap_last_idx = '0;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (|result_beats[i]) begin
                cap_last_idx = IDX_WIDTH'(i);
            end
        end
    end
`else
    assign cap_last_idx = LAST_FULL;
`endif

    assign streaming  = (state_q == STREAM);
    assign xfer       = streaming && out_if.ready;
    assign final_xfer = xfer && (cnt_q == last_idx_q);

    // Stream FSM, shadow capture and beat counter.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        drop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_i) begin
                    shadow_d   = result_beats;
                    cnt_d      = '0;
                    last_idx_d = cap_last_idx;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (final_xfer) begin
                    cnt_d = '0;
                    if (done_i) begin
                        // Back-to-back: new result takes over with no bubble.
                        shadow_d   = result_beats;
                        last_idx_d = cap_last_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // Result arriving mid-stream is lost; shadow is kept.
                    drop = done_i;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Error bookkeeping; a drop in the same cycle as a clear wins.
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overrun_d = 1'b1;
            if (clear_err_i) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (clear_err_i) begin
            overrun_d  = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            cnt_q      <= '0;
            last_idx_q <= LAST_FULL;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_if.valid    = streaming;
    assign out_if.data     = streaming ? shadow_q[cnt_q] : '0;
    assign out_if.beat_idx = cnt_q;
    assign out_if.last     = streaming && (cnt_q == last_idx_q);
    assign busy_o          = streaming;
    assign overrun_o       = overrun_q;
    assign drop_cnt_o      = drop_cnt_q;

    // A stalled beat must stay put until it is accepted.
    a_hold: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (out_if.valid && !out_if.ready)
            |=> (out_if.valid && $stable(out_if.data)
                 && $stable(out_if.beat_idx))
    );

    a_idle_idx: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !out_if.valid |-> (out_if.beat_idx == '0)
    );
endmodule

// File: tb/tb_wide_alu_result_streamer.sv
// Directed self-checking bench for wide_alu_result_streamer.
// Drives and samples on the falling edge; DUT state moves on the rising edge.
module tb_wide_alu_result_streamer;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         done_i;
    logic [511:0] result_i;
    logic         clear_err_i;
    logic         busy_o;
    logic         overrun_o;
    logic [7:0]   drop_cnt_o;

    int errors = 0;
    int checks = 0;

    wide_alu_result_streamer_if #(.BEAT_WIDTH(32), .IDX_WIDTH(4)) s_if ();

    wide_alu_result_streamer #(
        .RESULT_WIDTH(512),
        .BEAT_WIDTH  (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .done_i     (done_i),
        .result_i   (result_i),
        .clear_err_i(clear_err_i),
        .out_if     (s_if),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [511:0] ramp();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k*32 +: 32] = 32'h1000_0000 + k;
        end
        return r;
    endfunction

    task automatic start(input logic [511:0] r);
        @(negedge clk_i);
        done_i   = 1'b1;
        result_i = r;
        @(negedge clk_i);
        done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        done_i      = 1'b0;
        result_i    = '0;
        clear_err_i = 1'b0;
        s_if.ready  = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (s_if.valid !== 1'b0 || s_if.last !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%b last=%b busy=%b required 0 0 0",
                     s_if.valid, s_if.last, busy_o);
        end
        checks++;
        if (s_if.data !== 32'h0 || s_if.beat_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h idx=%0d required 0 0",
                     s_if.data, s_if.beat_idx);
        end
        checks++;
        if (overrun_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_err: overrun=%b drops=%0d required 0 0",
                     overrun_o, drop_cnt_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        s_if.ready = 1'b1;
        @(negedge clk_i);
        checks++;
        if (s_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: valid=%b required 0", s_if.valid);
        end
        done_i   = 1'b1;
        result_i = ramp();
        @(negedge clk_i);
        done_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = 32'h1000_0000 + k;
            checks++;
            if (s_if.valid !== 1'b1 || s_if.data !== exp
                || s_if.beat_idx !== 4'(k) || s_if.last !== (k == 15)
                || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: v=%b d=%h i=%0d l=%b b=%b required 1 %h %0d %b 1",
                         k, s_if.valid, s_if.data, s_if.beat_idx, s_if.last,
                         busy_o, exp, k, (k == 15));
            end
            @(negedge clk_i);
        end
        checks++;
        if (s_if.valid !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: valid=%b busy=%b required 0 0",
                     s_if.valid, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] exp;
        s_if.ready = 1'b0;
        start(ramp());
        n = 0;
        for (int c = 0; c < 100 && n < 16; c++) begin
            exp = 32'h1000_0000 + n;
            checks++;
            if (s_if.valid !== 1'b1 || s_if.data !== exp
                || s_if.beat_idx !== 4'(n)) begin
                errors++;
                $display("FAIL bp_cyc%0d: v=%b d=%h i=%0d required 1 %h %0d",
                         c, s_if.valid, s_if.data, s_if.beat_idx, exp, n);
            end
            s_if.ready = (c % 3 == 0);
            if (c % 3 == 0) n++;
            @(negedge clk_i);
        end
        s_if.ready = 1'b0;
        checks++;
        if (n != 16 || s_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: transfers=%0d valid=%b required 16 0",
                     n, s_if.valid);
        end
    endtask

    task automatic test_back_to_back();
        s_if.ready = 1'b1;
        start(ramp());
        for (int k = 0; k < 16; k++) begin
            if (k == 15) begin
                done_i   = 1'b1;
                result_i = {16{32'hAAAA_AAAA}};
            end
            @(negedge clk_i);
        end
        done_i = 1'b0;
        checks++;
        if (s_if.valid !== 1'b1 || s_if.beat_idx !== 4'd0
            || s_if.data !== 32'hAAAA_AAAA || overrun_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: v=%b i=%0d d=%h ovr=%b required 1 0 aaaaaaaa 0",
                     s_if.valid, s_if.beat_idx, s_if.data, overrun_o);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (s_if.beat_idx !== 4'(k) || s_if.data !== 32'hAAAA_AAAA) begin
                errors++;
                $display("FAIL b2b_beat%0d: i=%0d d=%h required %0d aaaaaaaa",
                         k, s_if.beat_idx, s_if.data, k);
            end
            @(negedge clk_i);
        end
        checks++;
        if (s_if.valid !== 1'b0 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b drops=%0d required 0 0",
                     s_if.valid, drop_cnt_o);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] exp;
        s_if.ready = 1'b1;
        start(ramp());
        for (int k = 0; k < 16; k++) begin
            exp = 32'h1000_0000 + k;
            checks++;
            if (s_if.data !== exp || s_if.beat_idx !== 4'(k)) begin
                errors++;
                $display("FAIL ovr_beat%0d: d=%h i=%0d required %h %0d",
                         k, s_if.data, s_if.beat_idx, exp, k);
            end
            done_i = (k == 3);
            result_i = {16{32'hFFFF_FFFF}};
            @(negedge clk_i);
        end
        done_i = 1'b0;
        checks++;
        if (s_if.valid !== 1'b0 || overrun_o !== 1'b1 || drop_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL ovr_one: v=%b ovr=%b drops=%0d required 0 1 1",
                     s_if.valid, overrun_o, drop_cnt_o);
        end
        s_if.ready = 1'b0;
        start(ramp());
        done_i = 1'b1;
        repeat (300) @(negedge clk_i);
        done_i = 1'b0;
        checks++;
        if (drop_cnt_o !== 8'd255 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sat: drops=%0d ovr=%b required 255 1",
                     drop_cnt_o, overrun_o);
        end
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b drops=%0d required 0 0",
                     overrun_o, drop_cnt_o);
        end
        clear_err_i = 1'b1;
        done_i      = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        done_i      = 1'b0;
        checks++;
        if (overrun_o !== 1'b1 || drop_cnt_o !== 8'd1
            || s_if.data !== 32'h1000_0000) begin
            errors++;
            $display("FAIL ovr_clr_drop: ovr=%b drops=%0d d=%h required 1 1 10000000",
                     overrun_o, drop_cnt_o, s_if.data);
        end
        s_if.ready = 1'b1;
        repeat (16) @(negedge clk_i);
        checks++;
        if (s_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_drain: valid=%b required 0", s_if.valid);
        end
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        s_if.ready = 1'b1;
        start(ramp());
        repeat (7) @(negedge clk_i);
        checks++;
        if (s_if.beat_idx !== 4'd7) begin
            errors++;
            $display("FAIL rstm_pre: idx=%0d required 7", s_if.beat_idx);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (s_if.valid !== 1'b0 || busy_o !== 1'b0 || s_if.beat_idx !== 4'd0
            || s_if.data !== 32'h0) begin
            errors++;
            $display("FAIL rstm_async: v=%b b=%b i=%0d d=%h required 0 0 0 0",
                     s_if.valid, busy_o, s_if.beat_idx, s_if.data);
        end
        @(negedge clk_i);
        done_i   = 1'b1;
        result_i = ramp();
        @(negedge clk_i);
        done_i = 1'b0;
        rst_i  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (s_if.valid !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rstm_post%0d: v=%b b=%b required 0 0",
                         c, s_if.valid, busy_o);
            end
        end
    endtask

    task automatic test_trim();
        logic [511:0] r;
        int           n;
        int           lidx;
        logic [31:0]  ldata;
        logic [31:0]  d8;
        int           exp_n;
        int           exp_idx;
        logic [31:0]  exp_ld;
        s_if.ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            r = '0;
            if (t == 0) r[256] = 1'b1;
`ifdef WIDE_ALU_STREAM_TRIM_EN
            exp_n   = (t == 0) ? 9 : 1;
            exp_idx = (t == 0) ? 8 : 0;
            exp_ld  = (t == 0) ? 32'h1 : 32'h0;
`else
            exp_n   = 16;
            exp_idx = 15;
            exp_ld  = 32'h0;
`endif
            start(r);
            n     = 0;
            lidx  = -1;
            ldata = 32'hDEAD_BEEF;
            d8    = 32'hDEAD_BEEF;
            for (int c = 0; c < 24 && lidx < 0; c++) begin
                if (s_if.valid === 1'b1) begin
                    n++;
                    if (s_if.beat_idx === 4'd8) d8 = s_if.data;
                    if (s_if.last === 1'b1) begin
                        lidx  = int'(s_if.beat_idx);
                        ldata = s_if.data;
                    end
                end
                @(negedge clk_i);
            end
            checks++;
            if (n != exp_n || lidx != exp_idx || ldata !== exp_ld) begin
                errors++;
                $display("FAIL trim%0d: beats=%0d last_idx=%0d last_d=%h required %0d %0d %h",
                         t, n, lidx, ldata, exp_n, exp_idx, exp_ld);
            end
            if (t == 0) begin
                checks++;
                if (d8 !== 32'h1) begin
                    errors++;
                    $display("FAIL trim_beat8: d=%h required 00000001", d8);
                end
            end
            checks++;
            if (s_if.valid !== 1'b0) begin
                errors++;
                $display("FAIL trim%0d_end: valid=%b required 0", t, s_if.valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_trim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
